dc_ipu_shr_pipeline_arbiter: RTL
================================

DC_IPU_SHR_PIPELINE_ARBITER -- requirements
Module: dc_ipu_shr_pipeline_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: payload bits per beat.
REQ-002 Parameter LAST_LOCK, default 1: 1 holds a grant until a beat with last=1 transfers; 0 re-arbitrates after every beat.
REQ-003 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 Port reset, input, 1: reset is synchronous and active-high.
REQ-005 Port clr, input, 1: synchronous flush of the arbiter state and the output stage.
REQ-006 Ports in0_valid/in1_valid, input, 1 each: requester beat valid.
REQ-007 Ports in0_ready/in1_ready, output, 1 each: requester beat accepted when ready and valid are both high.
REQ-008 Ports in0_data/in1_data, input, WIDTH each: requester payload.
REQ-009 Ports in0_last/in1_last, input, 1 each: last beat of a line/packet.
REQ-010 Port out_valid, output, 1: registered output beat valid.
REQ-011 Port out_ready, input, 1: downstream enable; a beat transfers when out_valid and out_ready are both high.
REQ-012 Ports out_data (WIDTH), out_last (1), out_sel (1), outputs: registered payload, last flag and source index of the output beat.

Function
REQ-013 The arbiter SHALL be a three-state FSM: IDLE, LOCK0, LOCK1.
REQ-014 In IDLE, a single valid input SHALL be granted in the same cycle; if both are valid, the input opposite to the priority pointer's last grant SHALL be granted (round robin).
REQ-015 The granted input's first beat SHALL be accepted in the grant cycle if the output stage can accept; no idle bubble on arbitration.
REQ-016 With LAST_LOCK=1, an accepted beat with last=0 SHALL move IDLE->LOCKn; in LOCKn only input n is ready; an accepted beat with last=1 SHALL return to IDLE.
REQ-017 With LAST_LOCK=0, the FSM SHALL remain in IDLE and arbitrate every beat.
REQ-018 The priority pointer SHALL update only when a beat with last=1 is accepted (LAST_LOCK=1) or on every accepted beat (LAST_LOCK=0).
REQ-019 The non-granted input's ready SHALL be 0; both readies SHALL be 0 in any cycle with reset or clr high.
REQ-020 Latency input-accept to out_valid SHALL be exactly 1 cycle; sustained throughput SHALL be 1 beat/cycle while out_ready=1.
REQ-021 Beats SHALL be neither dropped nor duplicated under any out_ready pattern; order within a source SHALL be preserved.
REQ-022 out_data/out_last/out_sel SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 A valid deasserted mid-packet in LOCKn SHALL keep LOCKn; the other input stays blocked.
REQ-024 clr SHALL take effect in the next cycle: FSM to IDLE, pointer to reset value, out_valid=0, any buffered beat discarded; a beat offered during clr is not accepted.

Reset
REQ-025 While reset is high at a clock edge: out_valid=0, out_data=0, out_last=0, out_sel=0, FSM=IDLE, pointer so input 0 wins the first tie.
REQ-026 reset SHALL take priority over clr and over any handshake in the same cycle.

Configuration
REQ-027 Macro DC_IPU_SHR_PIPELINE_ARBITER_SKID_EN defined: a one-entry side buffer SHALL be added. inN_ready SHALL then be driven from a register (grant qualified only), not from out_ready. A beat accepted while the output stalls SHALL be parked and restored to the output register when out_ready rises.
REQ-028 Macro undefined: no side buffer; inN_ready = grant_n & (!out_valid | out_ready), combinational from out_ready. Latency and ordering per REQ-020/021 in both builds.

Verification
REQ-029 Both inputs valid from cycle 0 with 3-beat packets (last on beat 3), out_ready=1 -> out_sel sequence 0,0,0,1,1,1,0,0,0; no gaps.
REQ-030 in0 packet mid-flight (beat 2 of 4), in1 asserts valid -> in1_ready stays 0 until in0 last beat is accepted; in1 granted next cycle.
REQ-031 out_ready low for 2 cycles during a stream of data 0..15 -> output carries 0..15 exactly once, in order, payload stable while stalled; repeat with SKID_EN defined and undefined.
REQ-032 LAST_LOCK=0, both inputs valid, last never asserted -> out_sel alternates 0,1,0,1 every cycle.
REQ-033 clr pulsed for 1 cycle while out_valid=1 and FSM in LOCK1 -> next cycle out_valid=0, FSM IDLE, first tie afterwards granted to input 0.
REQ-034 reset high 1 cycle mid-packet with both valid -> in0_ready=in1_ready=0 that cycle, all outputs zero next cycle, stream restarts cleanly.

Source files
------------

// File: rtl/dc_ipu_shr_pipeline_arbiter_if.sv
// Handshake bundle for the two-requester pipeline arbiter: two input beat
// channels (valid/ready/data/last) and one registered output channel that
// also reports which requester the beat came from.
interface dc_ipu_shr_pipeline_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             in0_valid;
  logic             in0_ready;
  logic [WIDTH-1:0] in0_data;
  logic             in0_last;
  logic             in1_valid;
  logic             in1_ready;
  logic [WIDTH-1:0] in1_data;
  logic             in1_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_sel;

  // Arbiter side.
  modport slave (
    input  in0_valid, in0_data, in0_last,
    input  in1_valid, in1_data, in1_last,
    input  out_ready,
    output in0_ready, in1_ready,
    output out_valid, out_data, out_last, out_sel
  );

  // Environment side: requesters plus downstream consumer.
  modport master (
    output in0_valid, in0_data, in0_last,
    output in1_valid, in1_data, in1_last,
    output out_ready,
    input  in0_ready, in1_ready,
    input  out_valid, out_data, out_last, out_sel
  );
endinterface

// File: rtl/dc_ipu_shr_pipeline_arbiter.sv
// Two-input round-robin packet arbiter with a registered output stage.
// LAST_LOCK=1 keeps a grant for a whole packet (until a last beat moves);
// LAST_LOCK=0 re-arbitrates every beat.
// Optional macro DC_IPU_SHR_PIPELINE_ARBITER_SKID_EN adds a one-entry side
// buffer so the input readies come from a register instead of out_ready.
module dc_ipu_shr_pipeline_arbiter #(
  parameter int WIDTH     = 8,
  parameter bit LAST_LOCK = 1'b1
) (
  input logic                         clk,
  input logic                         reset,
  input logic                         clr,
  dc_ipu_shr_pipeline_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOCK0 = 2'd1;
  localparam logic [1:0] LOCK1 = 2'd2;

  logic [1:0]       state;
  logic             ptr;          // requester that won the last completed grant
  logic             gnt_any;
  logic             gnt_sel;
  logic             sel_valid;
  logic [WIDTH-1:0] sel_data;
  logic             sel_last;
  logic             can_accept;
  logic             accept;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_last_q;
  logic             out_sel_q;

  // Pick the requester that owns the output this cycle.
  always_comb begin
    // NOTE: every output of a combinational block gets a default up front so no path leaves it unassigned (no latch).
    gnt_any = 1'b0;
    gnt_sel = 1'b0;
    case (state)
      LOCK0: begin
        gnt_any = 1'b1;
        gnt_sel = 1'b0;
      end
      LOCK1: begin
        gnt_any = 1'b1;
        gnt_sel = 1'b1;
      end
      default: begin
        if (bus.in0_valid && bus.in1_valid) begin
          gnt_any = 1'b1;
          gnt_sel = ~ptr;
        end else if (bus.in0_valid) begin
          gnt_any = 1'b1;
          gnt_sel = 1'b0;
        end else if (bus.in1_valid) begin
          gnt_any = 1'b1;
          gnt_sel = 1'b1;
        end
      end
    endcase
  end

  assign sel_valid = gnt_sel ? bus.in1_valid : bus.in0_valid;
  assign sel_data  = gnt_sel ? bus.in1_data  : bus.in0_data;
  assign sel_last  = gnt_sel ? bus.in1_last  : bus.in0_last;

  // Readies are forced low during reset or flush so nothing is taken then.
  assign bus.in0_ready = gnt_any & ~gnt_sel & can_accept & ~reset & ~clr;
  assign bus.in1_ready = gnt_any &  gnt_sel & can_accept & ~reset & ~clr;
  assign accept        = gnt_any & sel_valid & can_accept & ~reset & ~clr;

  // Packet lock state and round-robin pointer.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (reset || clr) begin
      state <= IDLE;
      ptr   <= 1'b1;
    end else if (accept) begin
      if (LAST_LOCK && !sel_last) state <= gnt_sel ? LOCK1 : LOCK0;
      else                        state <= IDLE;
      if (sel_last || !LAST_LOCK) ptr <= gnt_sel;
    end
  end

`ifdef DC_IPU_SHR_PIPELINE_ARBITER_SKID_EN
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             skid_last;
  logic             skid_sel;
  logic             ready_q;

  assign can_accept = ready_q;

  // Output register plus side buffer; a beat taken during a stall is parked.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= 1'b0;
      skid_valid  <= 1'b0;
      ready_q     <= 1'b1;
    end else if (clr) begin
      out_valid_q <= 1'b0;
      skid_valid  <= 1'b0;
      ready_q     <= 1'b1;
    end else if (!out_valid_q || bus.out_ready) begin
      if (skid_valid) begin
        out_valid_q <= 1'b1;
        out_data_q  <= skid_data;
        out_last_q  <= skid_last;
        out_sel_q   <= skid_sel;
        skid_valid  <= 1'b0;
        ready_q     <= 1'b1;
      end else if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= sel_data;
        out_last_q  <= sel_last;
        out_sel_q   <= gnt_sel;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= sel_data;
      skid_last  <= sel_last;
      skid_sel   <= gnt_sel;
      ready_q    <= 1'b0;
    end
  end
  // NOTE: the side-buffer payload is deliberately not reset; skid_valid alone says whether it holds anything.
`else
  assign can_accept = ~out_valid_q | bus.out_ready;

  // Output register: load on accept, drop valid once the beat has moved.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= 1'b0;
    end else if (clr) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sel_data;
      out_last_q  <= sel_last;
      out_sel_q   <= gnt_sel;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_sel   = out_sel_q;

endmodule
